pmt_count_uart_tx: RTL and testbench

- Back end of the timebin pipeline: takes the 16-bit PMT count and the one-cycle timebin strobe from the timebin trigger logic, and serialises the count onto the UART line to the PC as two 8N1 bytes.
- Latches the word on the strobe, so the counters may clear on the following cycle.
- Strobes that arrive while a frame is in flight are dropped and counted.

---
 rtl/pmt_count_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_pmt_count_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_count_uart_tx.sv
// Serialises a 16-bit PMT count as two back-to-back 8N1 UART bytes.
// A strobe that arrives mid-frame is dropped, pulses overrun and bumps a saturating counter.
module pmt_count_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [15:0] data,
  input  logic        stop_running,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [7:0]  overrun_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The byte sent first is the high byte exactly when MSB_FIRST is set.
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic second);
    return (MSB_FIRST ^ second) ? w[15:8] : w[7:0];
  endfunction

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] hold_q, hold_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;

  logic        go;
  logic        baud_end;

  assign go       = send && !stop_running;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    ovr_cnt_d  = ovr_cnt_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (go) begin
          state_d    = S_START;
          tx_d       = 1'b0;
          baud_d     = 16'd0;
          byte_idx_d = 1'b0;
          hold_d     = data;
          shift_d    = pick_byte(data, 1'b0);
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (!byte_idx_q) begin
            // Second byte follows its predecessor's stop bit with no idle gap.
            state_d    = S_START;
            tx_d       = 1'b0;
            byte_idx_d = 1'b1;
            shift_d    = pick_byte(hold_q, 1'b1);
          end else begin
            state_d    = S_IDLE;
            tx_d       = 1'b1;
            byte_idx_d = 1'b0;
            done_d     = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (go && busy_q) begin
      ovr_d     = 1'b1;
      ovr_cnt_d = sat_inc(ovr_cnt_q);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      shift_q    <= 8'd0;
      hold_q     <= 16'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun       = ovr_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_pmt_count_uart_tx.sv
// Bench for pmt_count_uart_tx: two instances (MSB-first and LSB-first) against a queue-based line model.
module tb_pmt_count_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 20 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        send = 1'b0;
  logic        stop_running = 1'b0;
  logic [15:0] data = 16'd0;

  logic       tx1, busy1, done1, ovr1;
  logic [7:0] cnt1;
  logic       tx0, busy0, done0, ovr0;
  logic [7:0] cnt0;

  pmt_count_uart_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .send(send), .data(data), .stop_running(stop_running),
    .tx(tx1), .busy(busy1), .done(done1), .overrun(ovr1), .overrun_count(cnt1));

  pmt_count_uart_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .send(send), .data(data), .stop_running(stop_running),
    .tx(tx0), .busy(busy0), .done(done0), .overrun(ovr0), .overrun_count(cnt0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes a list of per-cycle line levels.
  bit         mq0[$], mq1[$];
  logic [7:0] eb0[$], eb1[$];
  logic       m_tx0 = 1'b1, m_tx1 = 1'b1;
  logic       m_busy = 1'b0, m_done = 1'b0, m_ovr = 1'b0;
  int         m_cnt = 0;
  int         ovr_seen = 0;

  task automatic push_byte(input int k, input logic [7:0] b);
    for (int i = 0; i < 10 * CPB; i++) begin
      int bi;
      bit v;
      bi = i / CPB;
      v = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      if (k == 0) mq0.push_back(v);
      else mq1.push_back(v);
    end
  endtask

  task automatic model_update();
    bit was_busy;
    bit go;
    logic [7:0] hi, lo;
    was_busy = m_busy;
    go = send && !stop_running;
    m_done = 1'b0;
    m_ovr = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_tx0 = 1'b1; m_tx1 = 1'b1; m_cnt = 0;
      mq0.delete(); mq1.delete(); eb0.delete(); eb1.delete();
    end else if (was_busy) begin
      if (mq1.size() > 0) begin
        m_tx1 = mq1.pop_front();
        m_tx0 = mq0.pop_front();
      end else begin
        m_busy = 1'b0; m_done = 1'b1; m_tx1 = 1'b1; m_tx0 = 1'b1;
      end
      if (go) begin
        m_ovr = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (go) begin
      hi = data[15:8];
      lo = data[7:0];
      push_byte(1, hi); push_byte(1, lo);
      push_byte(0, lo); push_byte(0, hi);
      eb1.push_back(hi); eb1.push_back(lo);
      eb0.push_back(lo); eb0.push_back(hi);
      m_tx1 = mq1.pop_front();
      m_tx0 = mq0.pop_front();
      m_busy = 1'b1;
    end
  endtask

  // Independent UART receiver sampling each bit at its centre.
  int         d_act[2] = '{0, 0};
  int         d_cnt[2] = '{0, 0};
  logic [7:0] d_sh[2];

  task automatic decode(input int k, input logic line);
    int idx;
    logic [7:0] exp_b;
    if (reset) begin
      d_act[k] = 0;
      return;
    end
    if (d_act[k] == 0) begin
      if (line == 1'b0) begin
        d_act[k] = 1;
        d_cnt[k] = 0;
      end
    end else begin
      d_cnt[k]++;
    end
    if (d_act[k] != 0 && (d_cnt[k] % CPB) == CPB / 2) begin
      idx = d_cnt[k] / CPB;
      if (idx == 0) begin
        check(k ? "start_bit_msb" : "start_bit_lsb", line, 1'b0);
      end else if (idx <= 8) begin
        d_sh[k] = {line, d_sh[k][7:1]};
      end else begin
        check(k ? "stop_bit_msb" : "stop_bit_lsb", line, 1'b1);
        if (k == 1 && eb1.size() > 0) begin
          exp_b = eb1.pop_front();
          check("byte_msb", d_sh[k], exp_b);
        end else if (k == 0 && eb0.size() > 0) begin
          exp_b = eb0.pop_front();
          check("byte_lsb", d_sh[k], exp_b);
        end else begin
          check("extra_byte", 1, 0);
        end
        d_act[k] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("tx_msb", tx1, m_tx1);
    check("tx_lsb", tx0, m_tx0);
    check("busy", busy1, m_busy);
    check("busy_lsb", busy0, m_busy);
    check("done", done1, m_done);
    check("overrun", ovr1, m_ovr);
    check("ovr_count", cnt1, m_cnt[7:0]);
    check("ovr_count_lsb", cnt0, m_cnt[7:0]);
    if (ovr1) ovr_seen++;
    decode(1, tx1);
    decode(0, tx0);
  endtask

  task automatic wait_idle(output int busy_cycles, output bit saw_done);
    int n;
    n = 0;
    busy_cycles = 0;
    saw_done = 1'b0;
    while (m_busy && n < 4 * N) begin
      cyc();
      n++;
      if (busy1) busy_cycles++;
      if (done1) saw_done = 1'b1;
    end
    if (n >= 4 * N) check("idle_timeout", 0, 1);
  endtask

  int bc;
  bit sd;
  int ovr_base;

  initial begin
    repeat (3) cyc();
    check("reset_tx", tx1, 1'b1);
    check("reset_busy", busy1, 1'b0);
    check("reset_cnt", cnt1, 8'd0);
    reset = 1'b0;
    cyc();

    // Single frame, latency and length
    data = 16'hA55A; send = 1'b1;
    cyc();
    send = 1'b0;
    check("busy_rise", busy1, 1'b1);
    check("first_start", tx1, 1'b0);
    wait_idle(bc, sd);
    check("frame_len", bc + 1, N);
    check("frame_done", sd, 1'b1);
    repeat (3) cyc();

    // Back-to-back: send in the done cycle
    data = 16'h1234; send = 1'b1;
    cyc();
    send = 1'b0;
    for (int i = 0; i < 2 * N && !m_done; i++) cyc();
    check("b2b_done_seen", done1, 1'b1);
    data = 16'h00FF; send = 1'b1;
    cyc();
    send = 1'b0;
    check("b2b_start", tx1, 1'b0);
    check("b2b_ovr", ovr1, 1'b0);
    wait_idle(bc, sd);
    repeat (2) cyc();

    // Three drops during one frame
    ovr_base = ovr_seen;
    data = 16'hBEEF; send = 1'b1; cyc(); send = 1'b0;
    repeat (10) cyc();
    data = 16'h1111; send = 1'b1; cyc(); send = 1'b0;
    repeat (15) cyc();
    data = 16'h2222; send = 1'b1; cyc(); send = 1'b0;
    repeat (20) cyc();
    data = 16'h3333; send = 1'b1; cyc(); send = 1'b0;
    wait_idle(bc, sd);
    check("ovr_pulses3", ovr_seen - ovr_base, 3);
    check("ovr_count3", cnt1, 8'd3);

    // Saturation
    send = 1'b1;
    repeat (420) begin
      data = 16'($urandom);
      cyc();
    end
    send = 1'b0;
    wait_idle(bc, sd);
    check("ovr_sat", cnt1, 8'd255);

    // stop_running ignores sends
    stop_running = 1'b1;
    repeat (60) begin
      send = 1'($urandom_range(0, 1));
      data = 16'($urandom);
      cyc();
      check("stop_idle_busy", busy1, 1'b0);
    end
    send = 1'b0;

    // stop_running rising mid-frame
    stop_running = 1'b0;
    data = 16'($urandom); send = 1'b1; cyc(); send = 1'b0;
    repeat (20) cyc();
    stop_running = 1'b1;
    wait_idle(bc, sd);
    check("stop_mid_done", sd, 1'b1);
    stop_running = 1'b0;
    cyc();

    // Reset at cycle 30 of a frame
    data = 16'hC3A7; send = 1'b1; cyc(); send = 1'b0;
    repeat (28) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_mid_tx", tx1, 1'b1);
    check("rst_mid_busy", busy1, 1'b0);
    check("rst_mid_done", done1, 1'b0);
    repeat (3) cyc();
    data = 16'h5AA5; send = 1'b1; cyc(); send = 1'b0;
    wait_idle(bc, sd);
    check("post_rst_done", sd, 1'b1);

    // Randomised traffic
    repeat (3000) begin
      send = ($urandom_range(0, 29) == 0);
      data = 16'($urandom);
      stop_running = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc();
    end
    send = 1'b0; stop_running = 1'b0; reset = 1'b0;
    wait_idle(bc, sd);
    repeat (2) cyc();
    check("bytes_left", eb0.size() + eb1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
